// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch target buffer.
// The pipeline drives the master modport; the BTB implements the slave modport.
interface branch_target_buffer_if;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters, mispredict detection and redirect PC.
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module branch_target_buffer #(
  parameter int INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_target_buffer_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_mispredicts
`endif
);
  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  // Bit 1 of the encoding is the taken prediction.
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } ctr_t;

  logic                valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [31:0]         target_reg [ENTRIES];
  ctr_t                state_reg  [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;
  logic                  wr_hit;
  ctr_t                  state_next;
  logic                  mispredict_c;

  assign rd_idx = bus.if_pc[INDEX_BITS+1:2];
  assign rd_tag = bus.if_pc[31:INDEX_BITS+2];
  assign wr_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign wr_tag = bus.ex_pc[31:INDEX_BITS+2];

  // Lookup sees only registered contents, so a same-cycle update is not bypassed.
  always_comb begin
    bus.pred_hit    = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);
    bus.pred_taken  = bus.pred_hit && state_reg[rd_idx][1];
    bus.pred_target = bus.pred_taken ? target_reg[rd_idx] : bus.if_pc + 32'd4;
  end

  always_comb begin
    mispredict_c    = 1'b0;
    bus.redirect_pc = 32'd0;
    if (bus.ex_valid) begin
      mispredict_c    = (bus.ex_pred_taken != bus.ex_taken) ||
                        (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
      bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    end
  end
  assign bus.mispredict = mispredict_c;

  assign wr_hit = valid_reg[wr_idx] && (tag_reg[wr_idx] == wr_tag);

  always_comb begin
    state_next = state_reg[wr_idx];
    if (bus.ex_taken) begin
      case (state_reg[wr_idx])
        STRONG_NOT_TAKEN: state_next = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   state_next = WEAK_TAKEN;
        WEAK_TAKEN:       state_next = STRONG_TAKEN;
        default:          state_next = STRONG_TAKEN;
      endcase
    end else begin
      case (state_reg[wr_idx])
        STRONG_TAKEN:     state_next = WEAK_TAKEN;
        WEAK_TAKEN:       state_next = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   state_next = STRONG_NOT_TAKEN;
        default:          state_next = STRONG_NOT_TAKEN;
      endcase
    end
  end

  // Hits train the counter; taken misses allocate, evicting any aliasing entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= 32'd0;
        state_reg[i]  <= STRONG_NOT_TAKEN;
      end
    end else if (bus.ex_valid) begin
      if (wr_hit) begin
        state_reg[wr_idx] <= state_next;
        if (bus.ex_taken) target_reg[wr_idx] <= bus.ex_target;
      end else if (bus.ex_taken) begin
        valid_reg[wr_idx]  <= 1'b1;
        tag_reg[wr_idx]    <= wr_tag;
        target_reg[wr_idx] <= bus.ex_target;
        state_reg[wr_idx]  <= WEAK_TAKEN;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_reg;
  logic [31:0] hits_reg;
  logic [31:0] mispredicts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_reg     <= 32'd0;
      hits_reg        <= 32'd0;
      mispredicts_reg <= 32'd0;
    end else begin
      if (bus.ex_valid && (lookups_reg != 32'hFFFF_FFFF))
        lookups_reg <= lookups_reg + 32'd1;
      if (bus.ex_valid && wr_hit && (hits_reg != 32'hFFFF_FFFF))
        hits_reg <= hits_reg + 32'd1;
      if (mispredict_c && (mispredicts_reg != 32'hFFFF_FFFF))
        mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  assign stat_lookups     = lookups_reg;
  assign stat_hits        = hits_reg;
  assign stat_mispredicts = mispredicts_reg;
`endif
endmodule
